fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the MIPS core. Owns the program counter, issues single-outstanding word requests to instruction memory over a req/gnt + rvalid handshake, and hands each fetched instruction with its PC to decode over a valid/ready handshake. Applies branch/jump redirects and exception vectoring, and discards in-flight fetches made stale by them.

## Interface
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset.
- EXC_VECTOR, 32'h8000_0180: target on exception.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word address of request.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid (earliest: cycle after gnt).
- imem_rdata  in  32  instruction word.
- id_valid  out  1  instruction available to decode.
- id_instr  out  32  instruction word.
- id_pc  out  32  PC of id_instr.
- id_adr_err  out  1  misaligned fetch; id_instr is 0 (NOP).
- id_ready  in  1  decode accepts.
- redirect  in  1  branch/jump taken (one-cycle pulse).
- redirect_adr  in  32  branch/jump target.
- exc  in  1  exception (one-cycle pulse); priority over redirect.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- Reset: state IDLE, pc = RESET_VECTOR, kill = 0; imem_req 0, imem_addr RESET_VECTOR, id_valid 0, id_instr 0, id_pc 0, id_adr_err 0.
- IDLE -> REQ unconditionally.
- REQ: imem_req = 1, imem_addr = pc. gnt -> WAIT. Memory samples address only on gnt; imem_addr may change while ungranted only due to redirect/exc.
- WAIT: rvalid -> capture id_instr = imem_rdata, id_pc = pc, id_adr_err = 0 -> HOLD.
- HOLD: id_valid = 1; id_instr/id_pc stable until id_valid && id_ready; then pc <= pc + 4 (mod 2^32) -> REQ.
- DRAIN: request outstanding but stale; discard rvalid data -> REQ.
- Flush (exc or redirect): new target T = EXC_VECTOR if exc, else redirect_adr. pc <= T.
  - In IDLE/REQ: stay REQ (ungranted request retargets). If gnt in the same cycle, the granted request is stale -> DRAIN.
  - In WAIT: -> DRAIN, unless rvalid same cycle (data discarded) -> REQ.
  - In HOLD: id_valid drops next cycle -> REQ. A same-cycle id_ready handshake is void; flush source also clears decode.
  - In DRAIN: update pc only; stay DRAIN.
- Misaligned target (T[1:0] != 0): no memory request. Next state HOLD with id_valid 1, id_adr_err 1, id_instr 0, id_pc = T. On accept, pc <= T + 4 -> REQ. Exception handling belongs downstream.
- rvalid in IDLE, REQ, HOLD: ignored.

## Timing
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- Best case with gnt in REQ, rvalid next cycle and id_ready high is 3 cycles per instruction:
  - cycle n REQ (gnt), n+1 WAIT (rvalid), n+2 HOLD (accept), n+3 REQ for pc+4.
- After rst_n rises: first edge enters REQ, so imem_req is high in the 2nd cycle.
- Flush: request for T is visible the cycle after the flush pulse when not draining.
- Reset asserted mid-operation: immediate return to reset values. Any outstanding response is ignored because state is IDLE/REQ.

## Structure
- Shared package `mips_pkg`: state enum typedef (fetch_state_t), INSTR_NOP = 32'h0, default vector constants, word width 32.
- Single module. Optional sub-module `pc_next` (combinational T / pc+4 mux with alignment check). It can be inlined.
- Replaces free-running `pc` usage in the fetch path.

## Test plan
- Reset release, gnt/rvalid immediate, id_ready = 1: imem_addr sequence 0x0, 0x4, 0x8; id_pc matches; one instruction per 3 cycles.
- id_ready low 5 cycles in HOLD with rdata 0x2408_0001: id_valid held, id_instr/id_pc stable, no new imem_req.
- Redirect to 0x0000_0100 during WAIT: stale rvalid data not presented; next imem_addr 0x100; id_pc 0x100.
- exc and redirect (0x40) in the same cycle during HOLD: id_valid drops, next imem_addr 0x8000_0180.
- Redirect to 0x0000_0102: no imem_req; id_valid with id_adr_err 1, id_instr 0, id_pc 0x102; after accept, fetch 0x106 is not issued (pc <= 0x106 then misaligned path repeats) until a redirect arrives.
- rst_n asserted while in WAIT: outputs at reset values asynchronously; late rvalid after release ignored; first fetch from RESET_VECTOR.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS core types and constants.
// Provides the fetch FSM state type, the NOP encoding, the default reset and
// exception vectors, and the machine word width.
package mips_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h8000_0180;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: handshake bundles around the fetch sequencer.
// imem_if: req/addr out of fetch, gnt/rvalid/rdata back from instruction memory.
// id_if:   valid/instr/pc/adr_err out of fetch, ready back from decode.
interface imem_if;
    import mips_pkg::*;
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

interface id_if;
    import mips_pkg::*;
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            adr_err;
    logic            ready;
    modport master (output valid, instr, pc, adr_err, input ready);
    modport slave (input valid, instr, pc, adr_err, output ready);
endinterface

// File: rtl/fetch_ctrl_pc_next.sv
// pc_next: flush target selection, sequential increment and alignment checks.
// Ports: pc, exc, redirect, redirect_adr in; flush, tgt, tgt_mis, pc_inc, pc_mis out.
module pc_next
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic            exc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_adr,
    output logic            flush,
    output logic [XLEN-1:0] tgt,
    output logic            tgt_mis,
    output logic [XLEN-1:0] pc_inc,
    output logic            pc_mis
);
    assign flush   = exc | redirect;
    assign tgt     = exc ? EXC_VECTOR : redirect_adr;
    assign tgt_mis = |tgt[1:0];
    assign pc_inc  = pc + 32'd4;
    assign pc_mis  = |pc[1:0];
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC.
// Ports: clk, rst_n (async active-low); imem (master) single-outstanding
// req/gnt + rvalid fetch bus; id (master) valid/ready hand-off to decode;
// redirect/redirect_adr branch target pulse; exc exception pulse (wins).
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [XLEN-1:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    imem_if.master          imem,
    id_if.master            id,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_adr,
    input  logic            exc
);
    fetch_state_t    state, state_d;
    logic [XLEN-1:0] pc, pc_d, pc_inc, tgt;
    logic [XLEN-1:0] instr_q, id_pc_q, cap_instr, cap_pc;
    logic            err_q, cap, cap_err, flush, tgt_mis, pc_mis, outstanding;

    pc_next #(.EXC_VECTOR(EXC_VECTOR)) u_pc_next (
        .pc(pc), .exc(exc), .redirect(redirect), .redirect_adr(redirect_adr),
        .flush(flush), .tgt(tgt), .tgt_mis(tgt_mis), .pc_inc(pc_inc), .pc_mis(pc_mis)
    );

    // A granted-but-unanswered request means a response is still owed.
    assign outstanding = (state == REQ && imem.gnt && !pc_mis) || (state == WAIT && !imem.rvalid);

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        cap       = 1'b0;
        cap_instr = INSTR_NOP;
        cap_pc    = pc;
        cap_err   = 1'b0;
        case (state)
            IDLE: state_d = REQ;
            REQ: begin
                // A misaligned PC never reaches memory; it is reported to decode.
                if (pc_mis) begin
                    state_d = HOLD;
                    cap     = 1'b1;
                    cap_err = 1'b1;
                end else if (imem.gnt) state_d = WAIT;
            end
            WAIT: begin
                if (imem.rvalid) begin
                    state_d   = HOLD;
                    cap       = 1'b1;
                    cap_instr = imem.rdata;
                end
            end
            HOLD: begin
                if (id.ready) begin
                    pc_d    = pc_inc;
                    state_d = REQ;
                end
            end
            DRAIN: state_d = imem.rvalid ? REQ : DRAIN;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            pc_d      = tgt;
            cap       = 1'b0;
            cap_instr = INSTR_NOP;
            // DRAIN keeps waiting for its stale response, leaving once it lands
            // so a flush coinciding with that response cannot strand the FSM.
            if (state == DRAIN) state_d = imem.rvalid ? REQ : DRAIN;
            else if (outstanding) state_d = DRAIN;
            else if (tgt_mis) begin
                state_d = HOLD;
                cap     = 1'b1;
                cap_pc  = tgt;
                cap_err = 1'b1;
            end else state_d = REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_VECTOR;
            instr_q <= INSTR_NOP;
            id_pc_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            if (cap) begin
                instr_q <= cap_instr;
                id_pc_q <= cap_pc;
                err_q   <= cap_err;
            end
        end
    end

    assign imem.req   = (state == REQ) && !pc_mis;
    assign imem.addr  = pc;
    assign id.valid   = (state == HOLD);
    assign id.instr   = instr_q;
    assign id.pc      = id_pc_q;
    assign id.adr_err = err_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_adr = '0;
    logic        exc = 1'b0;
    int          checks = 0;
    int          errors = 0;

    imem_if imem ();
    id_if   id ();

    fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .imem(imem), .id(id),
        .redirect(redirect), .redirect_adr(redirect_adr), .exc(exc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        imem.gnt = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata = '0;
        id.ready = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(imem.req), 32'd0);
        chk("rst_addr", imem.addr, 32'h0);
        chk("rst_valid", 32'(id.valid), 32'd0);
        chk("rst_instr", id.instr, 32'h0);
        chk("rst_pc", id.pc, 32'h0);
        chk("rst_err", 32'(id.adr_err), 32'd0);
        // Streaming fetch: gnt/rvalid immediate, decode always ready.
        rst_n = 1'b1;
        tick();
        chk("t1_req0", 32'(imem.req), 32'd1);
        chk("t1_addr0", imem.addr, 32'h0);
        imem.gnt = 1'b1;
        imem.rvalid = 1'b1;
        imem.rdata = 32'h1111_0000;
        id.ready = 1'b1;
        tick();
        chk("t1_wait_req", 32'(imem.req), 32'd0);
        chk("t1_wait_valid", 32'(id.valid), 32'd0);
        tick();
        chk("t1_hold_valid", 32'(id.valid), 32'd1);
        chk("t1_hold_instr", id.instr, 32'h1111_0000);
        chk("t1_hold_pc", id.pc, 32'h0);
        tick();
        chk("t1_req1", 32'(imem.req), 32'd1);
        chk("t1_addr1", imem.addr, 32'h4);
        imem.rdata = 32'h1111_0004;
        tick();
        tick();
        chk("t1_instr1", id.instr, 32'h1111_0004);
        chk("t1_pc1", id.pc, 32'h4);
        tick();
        chk("t1_addr2", imem.addr, 32'h8);
        // Decode stalls in HOLD.
        id.ready = 1'b0;
        imem.rdata = 32'h2408_0001;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_valid", 32'(id.valid), 32'd1);
            chk("t2_instr", id.instr, 32'h2408_0001);
            chk("t2_pc", id.pc, 32'h8);
            chk("t2_req", 32'(imem.req), 32'd0);
        end
        id.ready = 1'b1;
        tick();
        chk("t2_addr_next", imem.addr, 32'hC);
        // Redirect during WAIT: stale data must be dropped.
        imem.rvalid = 1'b0;
        tick();
        imem.gnt = 1'b0;
        redirect = 1'b1;
        redirect_adr = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        chk("t3_drain_req", 32'(imem.req), 32'd0);
        chk("t3_drain_valid", 32'(id.valid), 32'd0);
        imem.rvalid = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        tick();
        chk("t3_stale_valid", 32'(id.valid), 32'd0);
        chk("t3_req", 32'(imem.req), 32'd1);
        chk("t3_addr", imem.addr, 32'h100);
        imem.rvalid = 1'b0;
        imem.gnt = 1'b1;
        tick();
        imem.rvalid = 1'b1;
        imem.rdata = 32'h3333_0100;
        tick();
        chk("t3_valid", 32'(id.valid), 32'd1);
        chk("t3_instr", id.instr, 32'h3333_0100);
        chk("t3_pc", id.pc, 32'h100);
        // exc and redirect together in HOLD; exc wins and the accept is void.
        exc = 1'b1;
        redirect = 1'b1;
        redirect_adr = 32'h0000_0040;
        tick();
        exc = 1'b0;
        redirect = 1'b0;
        chk("t4_valid", 32'(id.valid), 32'd0);
        chk("t4_req", 32'(imem.req), 32'd1);
        chk("t4_addr", imem.addr, 32'h8000_0180);
        imem.rdata = 32'h4444_0000;
        tick();
        tick();
        chk("t4_pc", id.pc, 32'h8000_0180);
        tick();
        chk("t4_addr_next", imem.addr, 32'h8000_0184);
        // Misaligned redirect target.
        imem.gnt = 1'b0;
        redirect = 1'b1;
        redirect_adr = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        chk("t5_req", 32'(imem.req), 32'd0);
        chk("t5_valid", 32'(id.valid), 32'd1);
        chk("t5_err", 32'(id.adr_err), 32'd1);
        chk("t5_instr", id.instr, 32'h0);
        chk("t5_pc", id.pc, 32'h102);
        tick();
        chk("t5_noreq", 32'(imem.req), 32'd0);
        chk("t5_novalid", 32'(id.valid), 32'd0);
        tick();
        chk("t5_rep_valid", 32'(id.valid), 32'd1);
        chk("t5_rep_err", 32'(id.adr_err), 32'd1);
        chk("t5_rep_pc", id.pc, 32'h106);
        chk("t5_rep_req", 32'(imem.req), 32'd0);
        redirect = 1'b1;
        redirect_adr = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        chk("t5_fix_req", 32'(imem.req), 32'd1);
        chk("t5_fix_addr", imem.addr, 32'h200);
        // Asynchronous reset while WAIT.
        imem.gnt = 1'b1;
        imem.rvalid = 1'b0;
        tick();
        chk("t6_wait_req", 32'(imem.req), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_addr", imem.addr, 32'h0);
        chk("t6_rst_pc", id.pc, 32'h0);
        chk("t6_rst_err", 32'(id.adr_err), 32'd0);
        chk("t6_rst_valid", 32'(id.valid), 32'd0);
        tick();
        imem.gnt = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata = 32'h0BAD_0BAD;
        rst_n = 1'b1;
        tick();
        chk("t6_req", 32'(imem.req), 32'd1);
        chk("t6_addr", imem.addr, 32'h0);
        tick();
        chk("t6_late_valid", 32'(id.valid), 32'd0);
        chk("t6_late_req", 32'(imem.req), 32'd1);
        imem.gnt = 1'b1;
        imem.rdata = 32'h5555_0000;
        tick();
        tick();
        chk("t6_instr", id.instr, 32'h5555_0000);
        chk("t6_pc", id.pc, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
